// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the multi-mode sequence generator.
// The optional SEQ_GEN_STEP_EN build uses the same package unchanged.
package seq_gen_pkg;

   typedef enum logic [2:0] {
      SEQ_UP      = 3'd0,
      SEQ_DOWN    = 3'd1,
      SEQ_GRAY    = 3'd2,
      SEQ_JOHNSON = 3'd3,
      SEQ_LFSR    = 3'd4
   } seq_mode_e;

   localparam logic [2:0] MODE_GRAY = SEQ_GRAY;

   // Widest state the Gray helper supports; narrower states are zero-extended.
   localparam int SEQ_MAX_W = 32;

   function automatic logic [SEQ_MAX_W-1:0] bin2gray(input logic [SEQ_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/seq_gen_next.sv
// Combinational next-state and wrap computation for every sequence mode.
// With SEQ_GEN_STEP_EN defined, UP/DOWN/GRAY advance by i_step modulo (limit+1).
module seq_gen_next
   import seq_gen_pkg::*;
#(
   parameter int               WIDTH     = 3,
   parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(3'b110)
) (
   input  logic [WIDTH-1:0] i_state,
   input  logic [2:0]       i_mode,
   input  logic [WIDTH-1:0] i_limit,
`ifdef SEQ_GEN_STEP_EN
   input  logic [WIDTH-1:0] i_step,
`endif
   output logic [WIDTH-1:0] o_next,
   output logic             o_wrap,
   output logic             o_valid
);

   logic [WIDTH-1:0] w_up_next, w_dn_next, w_jc_next, w_lf_next;
   logic             w_up_wrap, w_dn_wrap;

`ifdef SEQ_GEN_STEP_EN
   logic [WIDTH:0]   w_lim1, w_step_raw, w_step, w_st_ext, w_up_sum;
   logic [WIDTH-1:0] w_up_red, w_dn_red;

   // limit+1 needs the extra bit so limit=all-ones still gives a modulus of 2^WIDTH.
   assign w_lim1     = {1'b0, i_limit} + (WIDTH+1)'(1);
   assign w_step_raw = {1'b0, i_step};
   assign w_step     = (w_step_raw > {1'b0, i_limit}) ? (w_step_raw % w_lim1) : w_step_raw;
   assign w_st_ext   = {1'b0, i_state};
   assign w_up_sum   = w_st_ext + w_step;
   assign w_up_red   = WIDTH'(w_up_sum - w_lim1);
   assign w_dn_red   = WIDTH'(w_st_ext + w_lim1 - w_step);

   always_comb begin
      w_up_next = i_state;
      w_up_wrap = 1'b0;
      w_dn_next = i_state;
      w_dn_wrap = 1'b0;
      if (w_step != '0) begin
         if (w_up_sum > {1'b0, i_limit}) begin
            w_up_next = w_up_red;
            w_up_wrap = 1'b1;
         end else begin
            w_up_next = w_up_sum[WIDTH-1:0];
         end
         if (w_st_ext < w_step) begin
            w_dn_next = w_dn_red;
            w_dn_wrap = 1'b1;
         end else begin
            w_dn_next = i_state - w_step[WIDTH-1:0];
         end
      end
   end
`else
   assign w_up_wrap = (i_state >= i_limit);
   assign w_up_next = w_up_wrap ? '0 : i_state + WIDTH'(1);
   assign w_dn_wrap = (i_state == '0) || (i_state > i_limit);
   assign w_dn_next = w_dn_wrap ? i_limit : i_state - WIDTH'(1);
`endif

   assign w_jc_next = {i_state[WIDTH-2:0], ~i_state[WIDTH-1]};
   // All-zero state would lock the LFSR, so it is forced to 1.
   assign w_lf_next = (i_state == '0) ? WIDTH'(1)
                                      : {i_state[WIDTH-2:0], ^(i_state & LFSR_TAPS)};

   always_comb begin
      o_next  = i_state;
      o_wrap  = 1'b0;
      o_valid = 1'b0;
      case (seq_mode_e'(i_mode))
         SEQ_UP, SEQ_GRAY: begin
            o_next  = w_up_next;
            o_wrap  = w_up_wrap;
            o_valid = 1'b1;
         end
         SEQ_DOWN: begin
            o_next  = w_dn_next;
            o_wrap  = w_dn_wrap;
            o_valid = 1'b1;
         end
         SEQ_JOHNSON: begin
            o_next  = w_jc_next;
            o_wrap  = (w_jc_next == '0);
            o_valid = 1'b1;
         end
         SEQ_LFSR: begin
            o_next  = w_lf_next;
            o_wrap  = (w_lf_next == WIDTH'(1));
            o_valid = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/seq_gen_param.sv
// Parametrised multi-mode sequence generator: state/output registers, load priority, Gray decode.
// Optional macro SEQ_GEN_STEP_EN adds the `step` input for strided UP/DOWN/GRAY counting.
module seq_gen_param
   import seq_gen_pkg::*;
#(
   parameter int               WIDTH     = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(3'b110)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
`ifdef SEQ_GEN_STEP_EN
   input  logic [WIDTH-1:0] step,
`endif
   output logic [WIDTH-1:0] out,
   output logic             wrap
);

   logic [WIDTH-1:0] r_state, r_out;
   logic             r_wrap;
   logic [WIDTH-1:0] w_next, w_dec_next, w_dec_load;
   logic             w_wrap, w_valid;

   seq_gen_next #(
      .WIDTH     (WIDTH),
      .LFSR_TAPS (LFSR_TAPS)
   ) u_next (
      .i_state (r_state),
      .i_mode  (mode),
      .i_limit (limit),
`ifdef SEQ_GEN_STEP_EN
      .i_step  (step),
`endif
      .o_next  (w_next),
      .o_wrap  (w_wrap),
      .o_valid (w_valid)
   );

   // Output is decoded from the value being written, using the mode current at that edge.
   assign w_dec_next = (mode == MODE_GRAY) ? WIDTH'(bin2gray(SEQ_MAX_W'(w_next)))   : w_next;
   assign w_dec_load = (mode == MODE_GRAY) ? WIDTH'(bin2gray(SEQ_MAX_W'(load_val))) : load_val;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RESET_VAL;
         r_out   <= '0;
         r_wrap  <= 1'b0;
      end else if (load) begin
         r_state <= load_val;
         r_out   <= w_dec_load;
         r_wrap  <= 1'b0;
      end else if (en && w_valid) begin
         r_state <= w_next;
         r_out   <= w_dec_next;
         r_wrap  <= w_wrap;
      end else begin
         r_wrap  <= 1'b0;
      end
   end

   assign out  = r_out;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_seq_gen_param.sv
// Table-driven bench for seq_gen_param (WIDTH=3, taps 110) with a scoreboard queue.
// Build with SEQ_GEN_STEP_EN defined to exercise the strided counting vectors as well.
module tb_seq_gen_param;

   localparam logic [2:0] M_UP = 3'd0, M_DN = 3'd1, M_GR = 3'd2, M_JC = 3'd3, M_LF = 3'd4;

   logic       clk, rst, en, load, wrap;
   logic [2:0] mode, load_val, limit, out;
`ifdef SEQ_GEN_STEP_EN
   logic [2:0] step;
`endif

   typedef struct {
      logic       load;
      logic [2:0] load_val;
      logic       en;
      logic [2:0] mode;
      logic [2:0] limit;
      logic [2:0] step;
      logic [2:0] exp_out;
      logic       exp_wrap;
   } vec_t;

   typedef struct {
      logic [2:0] out;
      logic       wrap;
      string      name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   logic [2:0] gseq [8];

   seq_gen_param #(
      .WIDTH     (3),
      .RESET_VAL (3'd0),
      .LFSR_TAPS (3'b110)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .load     (load),
      .load_val (load_val),
      .limit    (limit),
`ifdef SEQ_GEN_STEP_EN
      .step     (step),
`endif
      .out      (out),
      .wrap     (wrap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic add(input logic ld, input logic [2:0] lv, input logic e, input logic [2:0] md,
                      input logic [2:0] lim, input logic [2:0] stp, input logic [2:0] eo, input logic ew);
      vec_t v;
      v.load = ld; v.load_val = lv; v.en = e; v.mode = md;
      v.limit = lim; v.step = stp; v.exp_out = eo; v.exp_wrap = ew;
      vecs.push_back(v);
   endtask

   task automatic expect_now(input logic [2:0] eo, input logic ew, input string name);
      exp_t e;
      e.out = eo; e.wrap = ew; e.name = name;
      sb.push_back(e);
   endtask

   task automatic check_pop();
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL scoreboard_empty: out=%0d wrap=%0b, no expected entry", out, wrap);
      end else begin
         e = sb.pop_front();
         if (out !== e.out || wrap !== e.wrap) begin
            fails++;
            $display("FAIL %s: got out=%0d wrap=%0b, expected out=%0d wrap=%0b",
                     e.name, out, wrap, e.out, e.wrap);
         end else begin
            $display("[TB] %s ok: out=%0d wrap=%0b", e.name, out, wrap);
         end
      end
   endtask

   task automatic apply_vec(input vec_t v, input string name);
      load = v.load; load_val = v.load_val; en = v.en; mode = v.mode; limit = v.limit;
`ifdef SEQ_GEN_STEP_EN
      step = v.step;
`endif
      expect_now(v.exp_out, v.exp_wrap, name);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   initial begin
      vec_t hv;
      rst = 1'b0; en = 1'b0; load = 1'b0; mode = M_UP; load_val = '0; limit = 3'd7;
`ifdef SEQ_GEN_STEP_EN
      step = 3'd1;
`endif

      // UP full range, then UP limit 4, then DOWN limit 4 from 0
      for (int k = 1; k <= 8; k++) add(0, 0, 1, M_UP, 7, 1, 3'(k % 8), k == 8);
      for (int k = 1; k <= 5; k++) add(0, 0, 1, M_UP, 4, 1, 3'(k % 5), k == 5);
      add(0, 0, 1, M_DN, 4, 1, 4, 1); add(0, 0, 1, M_DN, 4, 1, 3, 0);
      add(0, 0, 1, M_DN, 4, 1, 2, 0); add(0, 0, 1, M_DN, 4, 1, 1, 0);
      add(0, 0, 1, M_DN, 4, 1, 0, 0); add(0, 0, 1, M_DN, 4, 1, 4, 1);
      // GRAY from 0
      add(1, 0, 0, M_GR, 7, 1, 0, 0);
      gseq = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
      for (int k = 0; k < 8; k++) add(0, 0, 1, M_GR, 7, 1, gseq[k], k == 7);
      // JOHNSON then LFSR
      add(0, 0, 1, M_JC, 7, 1, 1, 0); add(0, 0, 1, M_JC, 7, 1, 3, 0);
      add(0, 0, 1, M_JC, 7, 1, 7, 0); add(0, 0, 1, M_JC, 7, 1, 6, 0);
      add(0, 0, 1, M_JC, 7, 1, 4, 0); add(0, 0, 1, M_JC, 7, 1, 0, 1);
      add(0, 0, 1, M_LF, 7, 1, 1, 1); add(0, 0, 1, M_LF, 7, 1, 2, 0);
      add(0, 0, 1, M_LF, 7, 1, 5, 0); add(0, 0, 1, M_LF, 7, 1, 3, 0);
      add(0, 0, 1, M_LF, 7, 1, 7, 0); add(0, 0, 1, M_LF, 7, 1, 6, 0);
      add(0, 0, 1, M_LF, 7, 1, 4, 0); add(0, 0, 1, M_LF, 7, 1, 1, 1);
      // mode change without en keeps out; next enabled edge re-decodes
      add(1, 2, 0, M_UP, 7, 1, 2, 0); add(0, 0, 1, M_UP, 7, 1, 3, 0);
      add(0, 0, 0, M_GR, 7, 1, 3, 0); add(0, 0, 1, M_GR, 7, 1, 6, 0);
      // reserved modes hold
      add(0, 0, 1, 3'd5, 7, 1, 6, 0); add(0, 0, 1, 3'd7, 7, 1, 6, 0);
      add(0, 0, 0, M_UP, 7, 1, 6, 0);
      // load priority over en, hold with en=0, load above limit
      add(1, 4, 0, M_UP, 7, 1, 4, 0); add(0, 0, 1, M_UP, 7, 1, 5, 0);
      add(1, 2, 1, M_UP, 7, 1, 2, 0);
      for (int k = 0; k < 3; k++) add(0, 0, 0, M_UP, 7, 1, 2, 0);
      add(1, 6, 0, M_UP, 4, 1, 6, 0);
`ifdef SEQ_GEN_STEP_EN
      add(0, 0, 1, M_UP, 4, 1, 2, 1); add(0, 0, 0, M_UP, 4, 1, 2, 0);
      // strided counting
      add(1, 0, 0, M_UP, 6, 3, 0, 0);
      add(0, 0, 1, M_UP, 6, 3, 3, 0); add(0, 0, 1, M_UP, 6, 3, 6, 0);
      add(0, 0, 1, M_UP, 6, 3, 2, 1); add(0, 0, 1, M_UP, 6, 3, 5, 0);
      add(0, 0, 1, M_UP, 6, 3, 1, 1); add(0, 0, 1, M_UP, 6, 0, 1, 0);
      add(0, 0, 1, M_DN, 6, 3, 5, 1); add(0, 0, 1, M_DN, 6, 3, 2, 0);
      add(1, 2, 0, M_UP, 2, 5, 2, 0); add(0, 0, 1, M_UP, 2, 5, 1, 1);
`else
      add(0, 0, 1, M_UP, 4, 1, 0, 1); add(0, 0, 0, M_UP, 4, 1, 0, 0);
      add(1, 6, 0, M_DN, 4, 1, 6, 0); add(0, 0, 1, M_DN, 4, 1, 4, 1);
      add(1, 3, 0, M_UP, 0, 1, 3, 0);
      add(0, 0, 1, M_UP, 0, 1, 0, 1); add(0, 0, 1, M_UP, 0, 1, 0, 1);
`endif

      // reset asserted before the first edge, then held across an enabled edge
      #2 rst = 1'b1;
      #1;
      expect_now(0, 0, "reset_assert");
      check_pop();
      en = 1'b1;
      @(posedge clk);
      #1;
      expect_now(0, 0, "reset_held_en");
      check_pop();
      #1 rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

      // asynchronous reset between edges while out=5
      hv.load = 1; hv.load_val = 3; hv.en = 0; hv.mode = M_UP; hv.limit = 7; hv.step = 1;
      hv.exp_out = 3; hv.exp_wrap = 0;
      apply_vec(hv, "pre_rst_load");
      hv.load = 0; hv.en = 1; hv.exp_out = 4;
      apply_vec(hv, "pre_rst_4");
      hv.exp_out = 5;
      apply_vec(hv, "pre_rst_5");
      #3 rst = 1'b1;
      #2;
      expect_now(0, 0, "async_rst_mid_cycle");
      check_pop();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      expect_now(1, 0, "post_rst_first");
      check_pop();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_gen_param.md
Name: seq_gen_param

Overview:
Parametrised, multi-mode sequence generator. It is the successor to the fixed 3-bit sequence generator. It produces a WIDTH-bit code sequence each enabled clock, selectable at run time:
- binary up
- binary down
- Gray
- Johnson
- LFSR

Features: programmable wrap limit, synchronous load, and a one-cycle wrap pulse. It sits in the stimulus/pattern section as a standalone sequence source.

Parameters:
- WIDTH, 3, output/state width (>=2)
- RESET_VAL, 0, state loaded on reset
- LFSR_TAPS, 3'b110, Fibonacci tap mask (bit i set = state bit i feeds XOR); WIDTH bits

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  advance sequence one step when high
- mode  in  3  0=UP 1=DOWN 2=GRAY 3=JOHNSON 4=LFSR; 5-7 reserved
- load  in  1  synchronous load of load_val into state
- load_val  in  WIDTH  load data
- limit  in  WIDTH  terminal value for UP/DOWN/GRAY
- out  out  WIDTH  registered sequence output
- wrap  out  1  registered one-cycle pulse on sequence wrap

Behaviour:
- Reset: one clock `clk`; asynchronous active-high reset `rst`.
  - On `rst`: state=RESET_VAL, out=0, wrap=0, immediately.
  - Reset asserted mid-run aborts the sequence; there is no partial update.
- Priority per edge: rst > load > en > hold.
- Load: state<=load_val and out<=decode(mode,load_val), both visible after the edge; wrap<=0.
- en=0 and no load: state and out hold; wrap<=0.
- Latency: out and wrap reflect the next state one clock after the enabling edge (registered; out=decode(mode,next_state)).
- UP: next = (state>=limit) ? 0 : state+1. wrap=1 when next wraps to 0. state>limit (e.g. after load or limit change) wraps to 0 with wrap. limit=0 gives constant 0 with wrap every enabled cycle.
- DOWN: next = (state==0 || state>limit) ? limit : state-1. wrap=1 on the jump to limit.
- GRAY: state counts exactly as UP; out = state ^ (state>>1). wrap as UP.
- JOHNSON: next = {state[WIDTH-2:0], ~state[WIDTH-1]}. Period 2*WIDTH from 0; limit ignored. wrap=1 when next==0. Invalid (non-Johnson) codes simply shift; there is no correction.
- LFSR:
  - fb = ^(state & LFSR_TAPS); next = {state[WIDTH-2:0], fb}.
  - Lock-up escape: state==0 gives next=1.
  - wrap=1 whenever next==1. limit ignored.
- Reserved modes: state and out hold even with en=1; wrap=0.
- Mode change: takes effect on the next enabled edge; state is not cleared. out is re-decoded only on that edge.
- Arithmetic: all WIDTH-bit unsigned; no carry out.

Optional Feature:
Macro SEQ_GEN_STEP_EN.
- Defined: adds input `step` (WIDTH bits). UP/GRAY/DOWN advance by step modulo (limit+1):
  - UP next = (state+step > limit) ? state+step-(limit+1) : state+step, computed at WIDTH+1 bits.
  - DOWN mirrors UP.
  - wrap when modulo reduction occurs.
  - step=0 holds with wrap=0.
  - step>limit is reduced modulo limit+1 first.
- Not defined: no step port; step fixed at 1; behaviour exactly as above.

Decomposition:
- Package seq_gen_pkg:
  - mode typedef (3-bit enum SEQ_UP..SEQ_LFSR)
  - mode constants
  - bin-to-Gray function
- One sub-module, seq_gen_next: purely combinational next-state/wrap computation per mode. The top holds only registers, priority logic and the output decode.

Test Plan:
1. WIDTH=3, mode=UP, limit=7, en=1 after reset -> out 0 (during reset), then 1,2,3,4,5,6,7,0 on successive edges; wrap=1 only with the 0.
2. UP limit=4 -> 1,2,3,4,0 (wrap). Then DOWN limit=4 from 0 -> 4 (wrap),3,2,1,0,4 (wrap).
3. GRAY limit=7 from 0 -> 001,011,010,110,111,101,100,000 (wrap on 000).
4. JOHNSON from 0 -> 001,011,111,110,100,000 (wrap). Then LFSR TAPS=110 from 0 -> 001 (wrap),010,101,011,111,110,100,001 (wrap).
5. UP running at 5, load=1 load_val=2 together with en=1 -> out=2, wrap=0. en=0 for 3 cycles -> out stays 2. Then load_val=6 with limit=4 and en -> out 0, wrap=1.
6. Assert rst asynchronously between edges while out=5 -> out=0 and wrap=0 immediately. With SEQ_GEN_STEP_EN, UP limit=6 step=3 from 0 -> 3,6,2 (wrap),5,1 (wrap).
